// File: rtl/ksa_adder_if.sv
// ksa_adder_if: operand and result bundle for the Kogge-Stone adder
interface ksa_adder_if #(parameter int BITS = 8);
  logic [BITS-1:0] a, b, sum;
  logic cin, cout;
  modport master(output a, b, cin, input sum, cout);
  modport slave(input a, b, cin, output sum, cout);
endinterface

// File: rtl/ksa_adder.sv
// ksa_adder: Kogge-Stone prefix adder with a registered sum and carry-out
module ksa_adder #(
  parameter int BITS = 8
) (
  input logic clk,
  input logic rst,
  ksa_adder_if.slave bus
);
  localparam int N = BITS + 1;
  localparam int LV = $clog2(N);
  // node j holds bit position j-1, so node 0 is the carry-in position
  logic [LV:0][N-1:0] g, p;
  logic [BITS-1:0] s;
  assign g[0] = {bus.a & bus.b, bus.cin};
  assign p[0] = {bus.a ^ bus.b, 1'b0};
  for (genvar k = 0; k < LV; k++) begin : lvl
    for (genvar j = 0; j < N; j++) begin : node
      if (j >= (1 << k)) begin : comb
        assign g[k+1][j] = g[k][j] | (p[k][j] & g[k][j-(1<<k)]);
        assign p[k+1][j] = p[k][j] & p[k][j-(1<<k)];
      end else begin : pass
        assign g[k+1][j] = g[k][j];
        assign p[k+1][j] = p[k][j];
      end
    end
  end
  assign s = p[0][N-1:1] ^ g[LV][N-2:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) {bus.cout, bus.sum} <= '0;
    else {bus.cout, bus.sum} <= {g[LV][N-1], s};
endmodule

// File: tb/tb_ksa_adder.sv
// tb_ksa_adder: scoreboard bench for ksa_adder at BITS=5, 1 and 32
module tb_ksa_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [5:0] q5[$];
  logic [1:0] q1[$];
  logic [32:0] q32[$];
  ksa_adder_if #(.BITS(5)) io5();
  ksa_adder_if #(.BITS(1)) io1();
  ksa_adder_if #(.BITS(32)) io32();
  ksa_adder #(.BITS(5)) dut5(.clk(clk), .rst(rst), .bus(io5.slave));
  ksa_adder #(.BITS(1)) dut1(.clk(clk), .rst(rst), .bus(io1.slave));
  ksa_adder #(.BITS(32)) dut32(.clk(clk), .rst(rst), .bus(io32.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ci, input logic [5:0] exp);
    logic [31:0] ra, rb;
    logic rc;
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom);
    @(negedge clk);
    io5.a = a; io5.b = b; io5.cin = ci;
    io1.a = a[0]; io1.b = b[0]; io1.cin = ci;
    io32.a = ra; io32.b = rb; io32.cin = rc;
    q5.push_back(exp);
    q1.push_back(2'(a[0]) + 2'(b[0]) + 2'(ci));
    q32.push_back({1'b0, ra} + {1'b0, rb} + 33'(rc));
  endtask
  always begin
    @(posedge clk);
    #1;
    if (q5.size() > 0) chk("sum5", 64'({io5.cout, io5.sum}), 64'(q5.pop_front()));
    if (q1.size() > 0) chk("sum1", 64'({io1.cout, io1.sum}), 64'(q1.pop_front()));
    if (q32.size() > 0) chk("sum32", 64'({io32.cout, io32.sum}), 64'(q32.pop_front()));
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    io5.a = '0; io5.b = '0; io5.cin = 1'b0;
    io1.a = '0; io1.b = '0; io1.cin = 1'b0;
    io32.a = '0; io32.b = '0; io32.cin = 1'b0;
    #3;
    chk("reset_init", 64'({io5.cout, io5.sum, io32.cout, io32.sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd13, 5'd12, 1'b0, 6'b0_11001);
    drive(5'd31, 5'd1, 1'b0, 6'b1_00000);
    drive(5'b01111, 5'd0, 1'b1, 6'b0_10000);
    drive(5'd31, 5'd31, 1'b1, 6'b1_11111);
    @(negedge clk);
    io5.a = 5'd13; io5.b = 5'd12; io5.cin = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_async", 64'({io5.cout, io5.sum}), 64'd0);
    chk("reset_async32", 64'({io32.cout, io32.sum}), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", 64'({io5.cout, io5.sum, io1.cout, io1.sum}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release", 64'({io5.cout, io5.sum}), 64'd0);
    drive(5'd13, 5'd12, 1'b0, 6'd25);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int c = 0; c < 2; c++)
          drive(5'(x), 5'(y), 1'(c), 6'(x + y + c));
    @(posedge clk);
    #2;
    chk("drained", 64'(q5.size() + q1.size() + q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
